// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions.
//   - funct3 width/sign codes for loads and stores
//   - lsu_state_t: bus controller states
//   - LSU_TIMEOUT_DEFAULT: default bus wait limit in cycles
package rv32i_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LSU_TIMEOUT_DEFAULT = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RWAIT = 2'd2,
      DONE  = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_bus_if.sv
// Word-bus between the load/store unit (master) and data memory (slave).
//   bus_req/bus_gnt      request handshake, request held until grant
//   bus_we               1 = write
//   bus_addr             word-aligned byte address
//   bus_wstrb/bus_wdata  byte enables and lane-positioned store data
//   bus_rvalid/bus_rdata read word return
interface lsu_bus_if #(
   parameter int ADDR_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_wstrb;
   logic [31:0]       bus_wdata;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3_i/is_store_i/off_i : current request, used for legality and store lanes
//   wdata_i                   : store data (rs2)
//   ld_funct3_i/ld_off_i      : captured funct3 and byte offset of the pending load
//   rdata_i                   : raw bus read word
//   bad_o                     : illegal funct3 or misaligned access
//   wstrb_o/wdata_o           : byte enables and replicated store data
//   rdata_o                   : extracted and extended load value
module lsu_align
   import rv32i_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic        is_store_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] rdata_i,
   output logic        bad_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Legality and alignment of the current request
   always_comb begin
      bad_o = 1'b0;
      case (funct3_i)
         F3_B:          bad_o = 1'b0;
         F3_H, F3_HU:   bad_o = (is_store_i && (funct3_i == F3_HU)) || off_i[0];
         F3_W:          bad_o = (off_i != 2'b00);
         F3_BU:         bad_o = is_store_i;
         default:       bad_o = 1'b1;
      endcase
   end

   // Store strobes; data is replicated so every enabled lane carries the right bytes
   always_comb begin
      wstrb_o = 4'b1111;
      wdata_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            wstrb_o = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         F3_H: begin
            wstrb_o = 4'b0011 << off_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            wstrb_o = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   assign byte_s = rdata_i[{ld_off_i, 3'b000} +: 8];
   assign half_s = rdata_i[{ld_off_i[1], 4'b0000} +: 16];

   // Load extraction and sign/zero extension
   always_comb begin
      rdata_o = rdata_i;
      case (ld_funct3_i)
         F3_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
         F3_H:    rdata_o = {{16{half_s[15]}}, half_s};
         F3_BU:   rdata_o = {24'd0, byte_s};
         F3_HU:   rdata_o = {16'd0, half_s};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns a core data-memory request into one
// handshaked word-bus transaction and stalls the core until it completes.
//   clk, rst_n             clock, asynchronous active-low reset
//   mem_read/mem_write     load / store request (both high = store)
//   funct3, addr, wdata    width code, byte address, store data
//   stall_o                hold PC/instruction (combinational)
//   rdata_o                formatted load data, held until the next load
//   misalign_o             one-cycle pulse, rejected access, no bus activity
//   bus_err_o              one-cycle pulse (in DONE) after a bus timeout
//   bus                    word-bus master port
module lsu_bus_ctrl
   import rv32i_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
   parameter int ADDR_W         = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall_o,
   output logic [31:0]       rdata_o,
   output logic              misalign_o,
   output logic              bus_err_o,
   lsu_bus_if.master         bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_wstrb_q, bus_wstrb_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;

   logic              access_s;
   logic              bad_s;
   logic              stall_s;
   logic              misalign_s;
   logic              expire_s;
   logic [3:0]        wstrb_s;
   logic [31:0]       wlanes_s;
   logic [31:0]       rfmt_s;

   assign access_s = mem_read | mem_write;

   lsu_align u_align (
      .funct3_i    (funct3),
      .is_store_i  (mem_write),
      .off_i       (addr[1:0]),
      .wdata_i     (wdata),
      .ld_funct3_i (f3_q),
      .ld_off_i    (off_q),
      .rdata_i     (bus.bus_rdata),
      .bad_o       (bad_s),
      .wstrb_o     (wstrb_s),
      .wdata_o     (wlanes_s),
      .rdata_o     (rfmt_s)
   );

   // The wait counter reaches TIMEOUT_CYCLES-1 at the end of this cycle.
   assign expire_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

   // Next-state, counter and output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = 1'b0;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      bus_err_d   = 1'b0;
      f3_d        = f3_q;
      off_d       = off_q;
      stall_s     = 1'b0;
      misalign_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_s && bad_s) begin
               misalign_s = 1'b1;
            end else if (access_s) begin
               stall_s     = 1'b1;
               bus_we_d    = mem_write;
               bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
               bus_wstrb_d = wstrb_s;
               bus_wdata_d = wlanes_s;
               f3_d        = funct3;
               off_d       = addr[1:0];
               cnt_d       = {CNT_W{1'b0}};
               bus_req_d   = 1'b1;
               state_d     = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (bus.bus_gnt && bus_we_q) begin
               state_d = DONE;
            end else if (bus.bus_gnt) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = RWAIT;
            end else if (expire_s) begin
               bus_err_d = 1'b1;
               state_d   = DONE;
               if (!bus_we_q) begin
                  rdata_d = 32'd0;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               bus_req_d = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         RWAIT: begin
            stall_s = 1'b1;
            if (bus.bus_rvalid) begin
               rdata_d = rfmt_s;
               state_d = DONE;
            end else if (expire_s) begin
               bus_err_d = 1'b1;
               rdata_d   = 32'd0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= {ADDR_W{1'b0}};
         bus_wstrb_q <= 4'd0;
         bus_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         bus_err_q   <= 1'b0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
      end
   end

   // The combinational responses are masked so reset always presents a quiet unit.
   assign stall_o        = stall_s & rst_n;
   assign misalign_o     = misalign_s & rst_n;
   assign rdata_o        = rdata_q;
   assign bus_err_o      = bus_err_q;
   assign bus.bus_req    = bus_req_q;
   assign bus.bus_we     = bus_we_q;
   assign bus.bus_addr   = bus_addr_q;
   assign bus.bus_wstrb  = bus_wstrb_q;
   assign bus.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        misalign_o;
   logic        bus_err_o;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_rdata = 32'd0;

   lsu_bus_if #(.ADDR_W(32)) bus_if ();

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .stall_o    (stall_o),
      .rdata_o    (rdata_o),
      .misalign_o (misalign_o),
      .bus_err_o  (bus_err_o),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: byte i of the bus word carries store byte (i mod size); strobes cover [off, off+size).
   function automatic void model_store(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] wd,
                                       output logic [3:0] strb, output logic [31:0] lanes);
      int size;
      size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < 4; i++) begin
         strb[i] = (i >= int'(off)) && (i < int'(off) + size);
         lanes[8*i +: 8] = wd[8*(i % size) +: 8];
      end
   endfunction

   // Reference: shift the word down by the byte offset, mask to size, optionally sign-extend.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      int size;
      longint unsigned v, lim;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      lim  = 64'd1 << (8 * size);
      v    = (64'(w) >> (8 * int'(off))) & (lim - 64'd1);
      if (!f3[2] && size < 4 && v >= (lim >> 1)) v = v - lim;
      return v[31:0];
   endfunction

   task automatic run_txn(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rword);
      logic is_st, legal, bad, abort, got;
      int size, i;
      logic [3:0] e_strb;
      logic [31:0] e_lanes;
      is_st = wr;
      legal = is_st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      bad   = !legal || ((int'(a[1:0]) % size) != 0);
      model_store(f3, a[1:0], wd, e_strb, e_lanes);
      // request cycle (IDLE)
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      #4;
      checks++; if (misalign_o !== bad) begin failures++; $display("FAIL %s misalign: got %b want %b", nm, misalign_o, bad); end
      checks++; if (stall_o !== !bad) begin failures++; $display("FAIL %s stall_idle: got %b want %b", nm, stall_o, !bad); end
      checks++; if (bus_if.bus_req !== 1'b0) begin failures++; $display("FAIL %s req_idle: got %b want 0", nm, bus_if.bus_req); end
      checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL %s err_idle: got %b want 0", nm, bus_err_o); end
      @(posedge clk); #1;
      if (bad) begin
         mem_read = 1'b0; mem_write = 1'b0;
         #4;
         checks++; if (misalign_o !== 1'b0 || bus_if.bus_req !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL %s after_misalign: misalign=%b req=%b stall=%b want 0,0,0", nm, misalign_o, bus_if.bus_req, stall_o);
         end
         @(posedge clk); #1;
         return;
      end
      // REQ phase
      abort = 1'b0; got = 1'b0; i = 0;
      while (!got && !abort) begin
         bus_if.bus_gnt = (i == gnt_dly);
         bus_if.bus_rvalid = 1'($urandom_range(0, 1));
         bus_if.bus_rdata = $urandom;
         #4;
         checks++; if (bus_if.bus_req !== 1'b1 || stall_o !== 1'b1) begin
            failures++; $display("FAIL %s req_phase%0d: req=%b stall=%b want 1,1", nm, i, bus_if.bus_req, stall_o);
         end
         checks++; if (bus_if.bus_we !== is_st || bus_if.bus_addr !== {a[31:2], 2'b00}) begin
            failures++; $display("FAIL %s req_addr: we=%b addr=%h want %b %h", nm, bus_if.bus_we, bus_if.bus_addr, is_st, {a[31:2], 2'b00});
         end
         if (is_st) begin
            checks++; if (bus_if.bus_wstrb !== e_strb || bus_if.bus_wdata !== e_lanes) begin
               failures++; $display("FAIL %s store_lanes: strb=%b data=%h want %b %h", nm, bus_if.bus_wstrb, bus_if.bus_wdata, e_strb, e_lanes);
            end
         end
         if (i == gnt_dly) got = 1'b1;
         else if (i == TMO - 2) abort = 1'b1;
         i++;
         @(posedge clk); #1;
      end
      bus_if.bus_gnt = 1'b0;
      // read data phase
      if (!is_st && got) begin
         got = 1'b0; i = 0;
         while (!got && !abort) begin
            bus_if.bus_rvalid = (i == rv_dly);
            bus_if.bus_rdata = (i == rv_dly) ? rword : $urandom;
            #4;
            checks++; if (bus_if.bus_req !== 1'b0 || stall_o !== 1'b1) begin
               failures++; $display("FAIL %s rwait%0d: req=%b stall=%b want 0,1", nm, i, bus_if.bus_req, stall_o);
            end
            if (i == rv_dly) begin got = 1'b1; exp_rdata = model_load(f3, a[1:0], rword); end
            else if (i == TMO - 2) abort = 1'b1;
            i++;
            @(posedge clk); #1;
         end
      end
      if (!is_st && abort) exp_rdata = 32'd0;
      // DONE cycle: core commits and drops the request; stray rvalid must be ignored
      mem_read = 1'b0; mem_write = 1'b0;
      bus_if.bus_rvalid = 1'($urandom_range(0, 1));
      bus_if.bus_rdata = $urandom;
      #4;
      checks++; if (stall_o !== 1'b0 || bus_if.bus_req !== 1'b0) begin
         failures++; $display("FAIL %s done: stall=%b req=%b want 0,0", nm, stall_o, bus_if.bus_req);
      end
      checks++; if (bus_err_o !== abort) begin failures++; $display("FAIL %s bus_err: got %b want %b", nm, bus_err_o, abort); end
      checks++; if (rdata_o !== exp_rdata) begin failures++; $display("FAIL %s rdata: got %h want %h", nm, rdata_o, exp_rdata); end
      @(posedge clk); #1;
      checks++; if (bus_err_o !== 1'b0 || rdata_o !== exp_rdata) begin
         failures++; $display("FAIL %s post_done: err=%b rdata=%h want 0 %h", nm, bus_err_o, rdata_o, exp_rdata);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
      #1 rst_n = 1'b0;
      #2;
      checks++; if ({stall_o, misalign_o, bus_err_o, bus_if.bus_req, bus_if.bus_we} !== 5'b0 ||
                    rdata_o !== 32'd0 || bus_if.bus_addr !== 32'd0 || bus_if.bus_wstrb !== 4'd0 || bus_if.bus_wdata !== 32'd0) begin
         failures++; $display("FAIL reset_state: stall=%b mis=%b err=%b req=%b we=%b rdata=%h addr=%h strb=%b wdata=%h want all 0",
                              stall_o, misalign_o, bus_err_o, bus_if.bus_req, bus_if.bus_we, rdata_o, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      exp_rdata = 32'd0;
   endtask

   task automatic test_reset_mid();
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h5000; wdata = 32'd0;
      bus_if.bus_gnt = 1'b0;
      @(posedge clk); #3;
      checks++; if (bus_if.bus_req !== 1'b1) begin failures++; $display("FAIL rst_mid_req: got %b want 1", bus_if.bus_req); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus_if.bus_req !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'd0 || bus_if.bus_addr !== 32'd0) begin
         failures++; $display("FAIL rst_mid_outputs: req=%b stall=%b rdata=%h addr=%h want 0", bus_if.bus_req, stall_o, rdata_o, bus_if.bus_addr);
      end
      mem_read = 1'b0;
      bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_rvalid = 1'b0;
      checks++; if (rdata_o !== 32'd0 || bus_if.bus_req !== 1'b0 || stall_o !== 1'b0) begin
         failures++; $display("FAIL rst_mid_after: rdata=%h req=%b stall=%b want 0", rdata_o, bus_if.bus_req, stall_o);
      end
      exp_rdata = 32'd0;
   endtask

   task automatic test_store_sb();
      run_txn("sb", 1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 0, 0, 32'd0);
   endtask

   task automatic test_load_half();
      run_txn("lh", 1'b1, 1'b0, 3'b001, 32'h2002, 32'd0, 0, 2, 32'h8001_1234);
      checks++; if (rdata_o !== 32'hFFFF8001) begin failures++; $display("FAIL lh_value: got %h want FFFF8001", rdata_o); end
      run_txn("lhu", 1'b1, 1'b0, 3'b101, 32'h2002, 32'd0, 0, 2, 32'h8001_1234);
      checks++; if (rdata_o !== 32'h00008001) begin failures++; $display("FAIL lhu_value: got %h want 00008001", rdata_o); end
   endtask

   task automatic test_misalign();
      run_txn("lw_mis", 1'b1, 1'b0, 3'b010, 32'h3001, 32'd0, 0, 0, 32'd0);
      run_txn("f3_011", 1'b1, 1'b0, 3'b011, 32'h3000, 32'd0, 0, 0, 32'd0);
      run_txn("sbu_ill", 1'b0, 1'b1, 3'b100, 32'h3000, 32'd0, 0, 0, 32'd0);
   endtask

   task automatic test_timeout();
      run_txn("tmo_gnt", 1'b1, 1'b0, 3'b010, 32'h4000, 32'd0, 1000, 0, 32'd0);
      run_txn("tmo_rv", 1'b1, 1'b0, 3'b000, 32'h4001, 32'd0, 0, 1000, 32'd0);
      run_txn("tmo_st", 1'b0, 1'b1, 3'b010, 32'h4008, 32'h12345678, 1000, 0, 32'd0);
   endtask

   task automatic test_back_to_back();
      run_txn("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h6004, 32'hCAFEF00D, 0, 0, 32'd0);
      run_txn("b2b_lb", 1'b1, 1'b1 ^ 1'b1, 3'b000, 32'h6005, 32'd0, 0, 0, 32'h1122_F344);
      checks++; if (rdata_o !== 32'hFFFFFFF3) begin failures++; $display("FAIL b2b_lb_value: got %h want FFFFFFF3", rdata_o); end
   endtask

   task automatic test_random();
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] a, wd, rw;
      for (int n = 0; n < 80; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if (!rd && !wr) rd = 1'b1;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            if (f3[1:0] == 2'd1) a[0] = 1'b0;
            else if (f3[1:0] != 2'd0) a[1:0] = 2'b00;
         end
         wd = $urandom;
         rw = $urandom;
         run_txn("rand", rd, wr, f3, a, wd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rw);
      end
   endtask

   initial begin
      test_reset();
      test_store_sb();
      test_load_half();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
